// File: rtl/mem_arb_pkg.sv
// Shared helpers for the memory port arbiter.
// Width functions used by the arbiter top and its ID FIFO.
package mem_arb_pkg;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the memory port arbiter.
// The arbiter takes the slave view; the surrounding fabric takes master.
interface mem_port_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*ADDR_WIDTH-1:0] add_i;
  logic [N_REQ-1:0]            wen_i;
  logic [N_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [N_REQ*BE_WIDTH-1:0]   be_i;
  logic [N_REQ-1:0]            gnt_o;
  logic [N_REQ-1:0]            r_valid_o;
  logic [DATA_WIDTH-1:0]       r_rdata_o;
  logic                        mem_req_o;
  logic [ADDR_WIDTH-1:0]       mem_add_o;
  logic                        mem_wen_o;
  logic [DATA_WIDTH-1:0]       mem_wdata_o;
  logic [BE_WIDTH-1:0]         mem_be_o;
  logic                        mem_gnt_i;
  logic                        mem_r_valid_i;
  logic [DATA_WIDTH-1:0]       mem_r_rdata_i;
  logic                        err_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    input  mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o,
    output mem_req_o, mem_add_o, mem_wen_o,
    output mem_wdata_o, mem_be_o, err_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    output mem_gnt_i, mem_r_valid_i, mem_r_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o,
    input  mem_req_o, mem_add_o, mem_wen_o,
    input  mem_wdata_o, mem_be_o, err_o
  );
endinterface

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted, unanswered requests.
// Caller never pushes when full nor pops when empty.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one req/gnt/r_valid memory port between
// N_REQ requesters, with in-order response steering via an ID FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IW       = id_w(N_REQ);
  localparam int CW       = cnt_w(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } mem_req_t;

  mem_req_t reqs [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign reqs[k].add   = bus.add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign reqs[k].wen   = bus.wen_i[k];
    assign reqs[k].wdata = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign reqs[k].be    = bus.be_i[k*BE_WIDTH +: BE_WIDTH];
  end

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      head;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [CW-1:0]      count;
  logic               any;
  logic               full;
  logic               empty;
  logic               mem_req;
  logic               hs;
  logic               pop;
  logic               err;
  int                 pos;

  // Rotate requests so that rr_ptr lands at bit 0, then pick lowest.
  always_comb begin
    dbl = {bus.req_i, bus.req_i} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
    win = '0;
    any = 1'b0;
    pos = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = int'(rr_ptr) + i;
        if (pos >= N_REQ) pos = pos - N_REQ;
        win = IW'(pos);
        any = 1'b1;
      end
    end
  end

  assign mem_req = any & ~full & ~reset;
  assign hs      = mem_req & bus.mem_gnt_i;
  assign pop     = bus.mem_r_valid_i & ~empty & ~reset;
  assign sel     = mem_req ? win : '0;

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_add_o   = reqs[sel].add;
  assign bus.mem_wen_o   = reqs[sel].wen;
  assign bus.mem_wdata_o = reqs[sel].wdata;
  assign bus.mem_be_o    = reqs[sel].be;
  assign bus.r_rdata_o   = bus.mem_r_rdata_i;
  assign bus.err_o       = err;

  always_comb begin
    bus.gnt_o = '0;
    if (hs) bus.gnt_o[win] = 1'b1;
  end

  always_comb begin
    bus.r_valid_o = '0;
    if (pop) bus.r_valid_o[head] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (hs)
      rr_ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (bus.mem_r_valid_i && empty)
      err <= 1'b1;
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .pop   (pop),
    .din   (win),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  logic unused;
  assign unused = ^count;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random traffic against a queue-based model of the
// arbiter: round-robin scan, outstanding-ID queue, sticky error.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  mem_port_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [DW-1:0] rdata;
  } pend_t;

  pend_t         outq[$];
  int            rr;
  bit            m_err;
  logic [DW-1:0] mem_arr [1<<AW];
  logic [AW-1:0] f_add   [N];
  logic          f_wen   [N];
  logic [DW-1:0] f_wdata [N];
  logic [BW-1:0] f_be    [N];
  logic [N-1:0]  hold;
  int            gcount  [N];
  bit            auto_mode;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_fields(input int k);
    f_add[k]   = AW'($urandom_range(15, 0));
    f_wen[k]   = 1'($urandom);
    f_wdata[k] = DW'($urandom);
    f_be[k]    = BW'($urandom);
  endtask

  task automatic cyc(input logic [N-1:0] rq, input logic g,
                     input logic rv, input logic rst_v);
    int            w;
    int            cnt;
    bit            exp_req;
    int            s;
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [DW-1:0] rd;
    logic [DW-1:0] nd;
    rd = (outq.size() > 0) ? outq[0].rdata : DW'($urandom);
    bus.req_i = rq;
    for (int k = 0; k < N; k++) begin
      bus.add_i[k*AW +: AW]   = f_add[k];
      bus.wen_i[k]            = f_wen[k];
      bus.wdata_i[k*DW +: DW] = f_wdata[k];
      bus.be_i[k*BW +: BW]    = f_be[k];
    end
    bus.mem_gnt_i     = g;
    bus.mem_r_valid_i = rv;
    bus.mem_r_rdata_i = rd;
    reset             = rst_v;
    #3;
    if (rst_v) begin
      outq.delete();
      rr    = 0;
      m_err = 1'b0;
    end
    cnt = outq.size();
    w = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (rr + i) % N;
      if (w < 0 && rq[j]) w = j;
    end
    exp_req = (w >= 0) && (cnt < MO) && !rst_v;
    eg = '0;
    if (exp_req && g) eg[w] = 1'b1;
    erv = '0;
    if (rv && cnt > 0 && !rst_v) erv[outq[0].id] = 1'b1;
    s = exp_req ? w : 0;
    chk("mem_req", 64'(bus.mem_req_o), 64'(exp_req));
    chk("gnt", 64'(bus.gnt_o), 64'(eg));
    chk("r_valid", 64'(bus.r_valid_o), 64'(erv));
    chk("r_rdata", 64'(bus.r_rdata_o), 64'(rd));
    chk("err", 64'(bus.err_o), 64'(m_err));
    chk("mem_add", 64'(bus.mem_add_o), 64'(f_add[s]));
    chk("mem_wen", 64'(bus.mem_wen_o), 64'(f_wen[s]));
    chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(f_wdata[s]));
    chk("mem_be", 64'(bus.mem_be_o), 64'(f_be[s]));
    @(posedge clk);
    #1;
    if (!rst_v) begin
      if (rv) begin
        if (cnt > 0) void'(outq.pop_front());
        else m_err = 1'b1;
      end
      if (exp_req && g) begin
        if (f_wen[w]) begin
          nd = mem_arr[f_add[w]];
        end else begin
          for (int b = 0; b < BW; b++)
            if (f_be[w][b])
              mem_arr[f_add[w]][b*8 +: 8] = f_wdata[w][b*8 +: 8];
          nd = DW'($urandom);
        end
        outq.push_back('{id: w, rdata: nd});
        rr = (w + 1) % N;
        gcount[w]++;
        if (auto_mode) hold[w] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * MO && outq.size() > 0; i++)
      cyc('0, 1'b0, 1'b1, 1'b0);
    chk("drained", 64'(outq.size()), 64'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rr        = 0;
    m_err     = 1'b0;
    auto_mode = 1'b0;
    hold      = '0;
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
    for (int k = 0; k < N; k++) begin
      new_fields(k);
      gcount[k] = 0;
    end
    reset = 1'b1;
    #1;
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc(2'b11, 1'b1, 1'b1, 1'b1);

    // single requester: store then load at address 5
    f_add[0] = 10'd5; f_wen[0] = 1'b0;
    f_wdata[0] = 32'hA5A5_0005; f_be[0] = 4'hF;
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    f_wen[0] = 1'b1;
    cyc(2'b01, 1'b1, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 1'b1, 1'b0);
    chk("single_rdata", 64'(bus.r_rdata_o), 64'h0000_0000_A5A5_0005);

    // fairness
    for (int k = 0; k < N; k++) gcount[k] = 0;
    for (int i = 0; i < 8; i++)
      cyc(2'b11, 1'b1, outq.size() > 0, 1'b0);
    chk("fair0", 64'(gcount[0]), 64'd4);
    chk("fair1", 64'(gcount[1]), 64'd4);
    drain();

    // backpressure
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // fifo full
    for (int i = 0; i < MO; i++) cyc(2'b11, 1'b1, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    chk("full_cnt", 64'(outq.size()), 64'(MO));
    cyc(2'b11, 1'b1, 1'b1, 1'b0);
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // spurious response
    cyc('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", 64'(bus.err_o), 64'd1);

    // reset mid-operation with two outstanding
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 1'b1, 1'b1);
    cyc(2'b11, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1, 1'b0);
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // random traffic
    auto_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        if (!hold[k] && $urandom_range(1, 0) == 1) begin
          hold[k] = 1'b1;
          new_fields(k);
        end
      cyc(hold, $urandom_range(3, 0) != 0,
          outq.size() > 0 && $urandom_range(1, 0) == 1, 1'b0);
    end
    auto_mode = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
